// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_flags
// Brief   : Single-clock FIFO with count, almost flags, error pulses, FWFT mode.
// Revision: 1.0
// ============================================================================
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0,
    localparam int CNT_W     = $clog2(MEM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = (MEM_DEPTH > 2) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] c_AF    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] c_AE    = CNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(MEM_DEPTH - 1);

    generate
        if (MEM_DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL ||
            AF_LEVEL > MEM_DEPTH || (FWFT != 0 && FWFT != 1)) begin : g_bad_params
            $error("fifo_sync_flags: illegal parameter combination");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    // Flags come only from the registered count, never from the requests.
    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    assign w_rd_acc = rd_en && !w_empty;
    assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr_en && !w_wr_acc;
            r_underflow <= rd_en && !w_rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
            assign dout = r_dout;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
